// File: rtl/oled_i2c_control_pkg.sv
// oled_pkg: shared definitions for the SSD1306 I2C controller.
//   - SSD1306 command constants used by the init and toggle sequences
//   - controller state enum (top level) and bus phase enum (tx engine)
//   - init command ROM, indexed 0..INIT_LEN-1
package oled_pkg;

   localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
   localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
   localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] CHARGE_PUMP_EN  = 8'h14;
   localparam logic [7:0] CMD_ENTIRE_ON   = 8'hA5;
   localparam logic [7:0] CTRL_CMD        = 8'h00;

   // Number of command bytes in the init transaction (after address + control)
   localparam int INIT_LEN = 5;

   typedef enum logic [1:0] {
      INIT_PEND,
      INIT_TX,
      IDLE,
      CMD_TX
   } state_t;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_START,
      PH_BIT,
      PH_STOP,
      PH_GAP
   } phase_t;

   // Init sequence: display off, enable charge pump, all pixels on, display on
   function automatic logic [7:0] init_cmd(input logic [2:0] i);
      logic [7:0] c;
      case (i)
         3'd0:    c = CMD_DISPLAY_OFF;
         3'd1:    c = CMD_CHARGE_PUMP;
         3'd2:    c = CHARGE_PUMP_EN;
         3'd3:    c = CMD_ENTIRE_ON;
         3'd4:    c = CMD_DISPLAY_ON;
         default: c = CMD_DISPLAY_ON;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/oled_i2c_control_tx_engine.sv
// i2c_tx_engine: write-only I2C master, push-pull SCL/SDA.
// Every bit is four quarter-phases of CLK_DIV clocks: SCL low in quarters
// 0-1 (SDA updated at the start of quarter 1), SCL high in quarters 2-3.
// The ninth bit of every byte releases SDA (ACK is not sampled).
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        begin a transaction; byte_in must already hold byte 0
//   byte_in      byte offered by the command source
//   last         byte_in is the final byte of the transaction
//   byte_valid   byte_in is meaningful; if low at a byte boundary, STOP
//   byte_req     one-clock pulse: byte_in has just been consumed
//   done         one-clock pulse after STOP plus four idle quarters
//   sck, sda     I2C lines, idle high
module i2c_tx_engine
   import oled_pkg::*;
#(
   parameter int CLK_DIV = 68
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic       last,
   input  logic       byte_valid,
   output logic       byte_req,
   output logic       done,
   output logic       sck,
   output logic       sda
);

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   phase_t          ph;
   logic [QW-1:0]   qcnt;
   logic [1:0]      q;
   logic [3:0]      bitn;
   logic [7:0]      sh;
   logic            lastf;
   logic            tick;

   assign tick = (qcnt == QW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         ph       <= PH_IDLE;
         qcnt     <= '0;
         q        <= '0;
         bitn     <= '0;
         lastf    <= 1'b0;
         sck      <= 1'b1;
         sda      <= 1'b1;
         byte_req <= 1'b0;
         done     <= 1'b0;
      end else begin
         byte_req <= 1'b0;
         done     <= 1'b0;
         if (ph != PH_IDLE)
            qcnt <= tick ? '0 : qcnt + 1'b1;

         case (ph)
            PH_IDLE: begin
               qcnt <= '0;
               q    <= '0;
               if (start && byte_valid) begin
                  // START: SDA falls while SCL is still high
                  sda      <= 1'b0;
                  lastf    <= last;
                  byte_req <= 1'b1;
                  ph       <= PH_START;
               end
            end

            PH_START: begin
               // Hold the START condition for two quarters, then pull SCL low
               if (tick) begin
                  if (q == 2'd1) begin
                     q    <= '0;
                     bitn <= '0;
                     sck  <= 1'b0;
                     ph   <= PH_BIT;
                  end else begin
                     q <= q + 2'd1;
                  end
               end
            end

            PH_BIT: begin
               if (tick) begin
                  q <= q + 2'd1;
                  case (q)
                     2'd0: sda <= (bitn == 4'd8) ? 1'b1 : sh[7];
                     2'd1: sck <= 1'b1;
                     2'd2: ;
                     default: begin
                        sck <= 1'b0;
                        if (bitn != 4'd8) begin
                           bitn <= bitn + 4'd1;
                        end else if (!lastf && byte_valid) begin
                           lastf    <= last;
                           byte_req <= 1'b1;
                           bitn     <= '0;
                        end else begin
                           ph <= PH_STOP;
                        end
                     end
                  endcase
               end
            end

            PH_STOP: begin
               // SDA low under SCL low, raise SCL, then SDA rises (STOP)
               if (tick) begin
                  q <= q + 2'd1;
                  case (q)
                     2'd0: sda <= 1'b0;
                     2'd1: sck <= 1'b1;
                     2'd2: ;
                     default: begin
                        sda <= 1'b1;
                        ph  <= PH_GAP;
                     end
                  endcase
               end
            end

            PH_GAP: begin
               // Bus free time before the next START can be accepted
               if (tick) begin
                  q <= q + 2'd1;
                  if (q == 2'd3) begin
                     ph   <= PH_IDLE;
                     done <= 1'b1;
                  end
               end
            end

            default: ph <= PH_IDLE;
         endcase
      end
   end

   // Shift register is pure data: loaded with a new byte or shifted per bit
   always_ff @(posedge clk) begin
      if (ph == PH_IDLE && start && byte_valid)
         sh <= byte_in;
      else if (ph == PH_BIT && tick && q == 2'd3)
         sh <= (bitn == 4'd8) ? byte_in : {sh[6:0], 1'b0};
   end

endmodule

// File: rtl/oled_i2c_control.sv
// oled_i2c_control: SSD1306 controller over write-only I2C.
// After reset it sends the init sequence (panel fully lit); each debounced
// press of the active-low button toggles the display off/on.
// Ports:
//   clk      system clock (27 MHz nominal)
//   rst      synchronous active-high reset
//   bbutton  push button, active-low, asynchronous to clk
//   sck      I2C SCL, push-pull, idle high
//   sda      I2C SDA, push-pull, idle high
module oled_i2c_control
   import oled_pkg::*;
#(
   parameter int         CLK_DIV         = 68,
   parameter int         DEBOUNCE_CYCLES = 100,
   parameter logic [6:0] OLED_ADDR       = 7'h3C
) (
   input  logic clk,
   input  logic rst,
   input  logic bbutton,
   output logic sck,
   output logic sda
);

   localparam int         DW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [7:0] ADDR_BYTE = {OLED_ADDR, 1'b0};

   logic          sync1;
   logic          sync2;
   logic          btn_db;
   logic [DW-1:0] dcnt;
   logic          press;

   state_t        state;
   logic          display_on;
   logic          pending;
   logic          start;
   logic [7:0]    cmd;
   logic [2:0]    idx;

   logic [7:0]    byte_in;
   logic          last;
   logic          byte_valid;
   logic          byte_req;
   logic          done;

   // Button: 2-flop synchronizer, then accept a new level only after
   // DEBOUNCE_CYCLES consecutive samples that differ from the current one.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         btn_db <= 1'b1;
         dcnt   <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= bbutton;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == btn_db) begin
            dcnt <= '0;
         end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= sync2;
            dcnt   <= '0;
            // Only the released->pressed transition is an event
            press  <= btn_db;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT_PEND;
         display_on <= 1'b0;
         pending    <= 1'b0;
         start      <= 1'b0;
         cmd        <= CMD_DISPLAY_OFF;
         idx        <= '0;
      end else begin
         start <= 1'b0;
         if (byte_req)
            idx <= idx + 3'd1;

         case (state)
            INIT_PEND: begin
               state <= INIT_TX;
               start <= 1'b1;
               idx   <= '0;
            end

            INIT_TX: begin
               if (press)
                  pending <= 1'b1;
               if (done) begin
                  display_on <= 1'b1;
                  state      <= IDLE;
               end
            end

            IDLE: begin
               if (press || pending) begin
                  pending <= 1'b0;
                  cmd     <= display_on ? CMD_DISPLAY_OFF : CMD_DISPLAY_ON;
                  state   <= CMD_TX;
                  start   <= 1'b1;
                  idx     <= '0;
               end
            end

            CMD_TX: begin
               // A press that coincides with done still queues: it is
               // picked up on the first IDLE cycle.
               if (press)
                  pending <= 1'b1;
               if (done) begin
                  display_on <= ~display_on;
                  state      <= IDLE;
               end
            end

            default: state <= INIT_PEND;
         endcase
      end
   end

   // Command source: address, control byte, then the command payload
   always_comb begin
      byte_in    = CTRL_CMD;
      last       = 1'b0;
      byte_valid = 1'b0;
      if (state == INIT_TX) begin
         byte_valid = (idx < 3'(INIT_LEN + 2));
         last       = (idx == 3'(INIT_LEN + 1));
         case (idx)
            3'd0:    byte_in = ADDR_BYTE;
            3'd1:    byte_in = CTRL_CMD;
            default: byte_in = init_cmd(idx - 3'd2);
         endcase
      end else if (state == CMD_TX) begin
         byte_valid = (idx < 3'd3);
         last       = (idx == 3'd2);
         case (idx)
            3'd0:    byte_in = ADDR_BYTE;
            3'd1:    byte_in = CTRL_CMD;
            default: byte_in = cmd;
         endcase
      end
   end

   i2c_tx_engine #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_in    (byte_in),
      .last       (last),
      .byte_valid (byte_valid),
      .byte_req   (byte_req),
      .done       (done),
      .sck        (sck),
      .sda        (sda)
   );

endmodule

// File: tb/tb_oled_i2c_control.sv
`timescale 1ns/1ps
module tb_oled_i2c_control;

   localparam int CLK_DIV = 20;
   localparam int DEB     = 100;
   localparam int Q       = 4 * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bbutton = 1'b1;
   logic sck;
   logic sda;

   always #5 clk = ~clk;

   oled_i2c_control #(
      .CLK_DIV         (CLK_DIV),
      .DEBOUNCE_CYCLES (DEB),
      .OLED_ADDR       (7'h3C)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bbutton (bbutton),
      .sck     (sck),
      .sda     (sda)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected transactions as byte lists, plus the
   // display/pending rules applied per press and per completed transaction.
   logic [7:0] exp_b[$];
   int         exp_n[$];
   bit         disp_m, pend_m, busy_m, init_m;

   task automatic push_tx(input bit is_init);
      exp_b.push_back(8'h78);
      exp_b.push_back(8'h00);
      if (is_init) begin
         exp_b.push_back(8'hAE); exp_b.push_back(8'h8D); exp_b.push_back(8'h14);
         exp_b.push_back(8'hA5); exp_b.push_back(8'hAF);
         exp_n.push_back(7);
      end else begin
         exp_b.push_back(disp_m ? 8'hAE : 8'hAF);
         exp_n.push_back(3);
      end
   endtask

   task automatic model_reset();
      exp_b.delete(); exp_n.delete();
      disp_m = 0; pend_m = 0; init_m = 1; busy_m = 1;
      push_tx(1);
   endtask

   task automatic model_press();
      if (busy_m) pend_m = 1;
      else begin push_tx(0); busy_m = 1; end
   endtask

   task automatic model_done();
      disp_m = init_m ? 1'b1 : ~disp_m;
      init_m = 0;
      busy_m = 0;
      if (pend_m) begin pend_m = 0; push_tx(0); busy_m = 1; end
   endtask

   // Bus monitor, sampled on the falling clock edge
   logic       prev_sck = 1, prev_sda = 1, rise_sda = 1;
   bit         in_frame = 0, hi_ok = 0, seen_stop = 0, skip = 0;
   int         bitpos = 0, hi_cnt = 0, idle_cnt = 0, n_starts = 0, n_frames = 0;
   logic [7:0] cur = 0;
   logic [7:0] got_b[$];

   task automatic frame_compare();
      int en;
      en = (exp_n.size() != 0) ? exp_n[0] : 0;
      chk("tx_len", got_b.size(), en);
      for (int i = 0; i < got_b.size() && i < en; i++)
         chk("tx_byte", int'(got_b[i]), int'(exp_b[i]));
      for (int i = 0; i < en; i++) void'(exp_b.pop_front());
      if (exp_n.size() != 0) void'(exp_n.pop_front());
   endtask

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0; seen_stop = 0; hi_ok = 0; skip = 1; idle_cnt = 0;
      end else if (skip) begin
         skip = 0; idle_cnt = 0;
      end else begin
         if (prev_sck && sck && prev_sda && !sda) begin
            chk("start_outside_frame", int'(in_frame), 0);
            if (seen_stop) chk("bus_free_time", int'(idle_cnt >= Q), 1);
            in_frame = 1; bitpos = 0; got_b.delete(); hi_ok = 0; n_starts++;
         end else if (prev_sck && sck && !prev_sda && sda) begin
            chk("stop_in_frame", int'(in_frame), 1);
            chk("stop_on_byte_boundary", bitpos, 0);
            frame_compare();
            in_frame = 0; seen_stop = 1; hi_ok = 0; n_frames++;
            model_done();
         end
         if (!prev_sck && sck) begin
            hi_cnt = 1; hi_ok = in_frame; rise_sda = sda;
         end else if (prev_sck && sck) begin
            hi_cnt++;
         end else if (prev_sck && !sck && hi_ok) begin
            chk("scl_high_time", hi_cnt, 2 * CLK_DIV);
            hi_ok = 0;
            if (bitpos < 8) begin
               cur = {cur[6:0], rise_sda};
               bitpos++;
               if (bitpos == 8) got_b.push_back(cur);
            end else begin
               chk("ack_released", int'(rise_sda), 1);
               bitpos = 0;
            end
         end
         idle_cnt = (sck && sda) ? idle_cnt + 1 : 0;
      end
      prev_sck = sck;
      prev_sda = sda;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_low(input int len, input bit counts);
      bbutton = 1'b0;
      for (int i = 0; i < len; i++) begin
         cyc();
         if (counts && i == DEB + 4) model_press();
      end
      bbutton = 1'b1;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(busy_m == 0 && idle_cnt >= 200) && t < 30000) begin
         cyc();
         t++;
      end
      chk("wait_idle_in_time", int'(t < 30000), 1);
   endtask

   task automatic release_and_check_start();
      int cnt;
      rst = 1'b0;
      cnt = 0;
      while (sda && cnt < 10) begin
         cyc();
         cnt++;
      end
      chk("start_latency", cnt, 2);
      chk("start_sck_high", int'(sck), 1);
   endtask

   initial begin
      int s0, f0, t, mode;
      model_reset();
      rst = 1'b1;
      repeat (5) cyc();
      chk("rst_sck", int'(sck), 1);
      chk("rst_sda", int'(sda), 1);
      chk("rst_display_on", int'(dut.display_on), 0);
      release_and_check_start();

      // Press during init: queued and serviced after init completes
      repeat (998) cyc();
      hold_low(250, 1);
      repeat (DEB + 30) cyc();
      wait_idle();
      chk("display_after_pending", int'(dut.display_on), int'(disp_m));

      // Press while idle
      hold_low($urandom_range(DEB + 20, DEB + 150), 1);
      repeat (DEB + 30) cyc();
      wait_idle();
      chk("display_after_press", int'(dut.display_on), int'(disp_m));

      // Glitch shorter than the debounce window
      s0 = n_starts;
      hold_low($urandom_range(40, DEB - 15), 0);
      repeat (600) cyc();
      chk("glitch_no_tx", n_starts - s0, 0);
      chk("glitch_sck", int'(sck), 1);
      chk("glitch_sda", int'(sda), 1);

      // Random mix: single press, or three presses inside one transaction
      for (int it = 0; it < 4; it++) begin
         mode = $urandom_range(0, 1);
         s0 = n_starts;
         f0 = n_frames;
         hold_low($urandom_range(DEB + 20, DEB + 150), 1);
         repeat (DEB + 30) cyc();
         if (mode == 1) begin
            t = 0;
            while (n_starts == s0 && t < 2000) begin cyc(); t++; end
            chk("tx_started", int'(n_starts > s0), 1);
            repeat ($urandom_range(50, 200)) cyc();
            for (int k = 0; k < 3; k++) begin
               hold_low(DEB + $urandom_range(10, 50), 1);
               repeat (DEB + $urandom_range(20, 60)) cyc();
            end
         end
         wait_idle();
         chk("tx_count", n_frames - f0, (mode == 1) ? 2 : 1);
         chk("display_state", int'(dut.display_on), int'(disp_m));
      end

      // Reset in the middle of the third init byte
      rst = 1'b1;
      model_reset();
      repeat (2) cyc();
      release_and_check_start();
      t = 0;
      while (!(in_frame && got_b.size() == 2 && bitpos >= 3 && !sck) && t < 20000) begin
         cyc();
         t++;
      end
      chk("reach_byte3", int'(t < 20000), 1);
      chk("byte3_sck_low", int'(sck), 0);
      rst = 1'b1;
      model_reset();
      cyc();
      chk("midrst_sck", int'(sck), 1);
      chk("midrst_sda", int'(sda), 1);
      release_and_check_start();
      wait_idle();
      chk("display_after_reinit", int'(dut.display_on), 1);
      chk("leftover_tx", exp_n.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #(900_000);
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/oled_i2c_control.md
Name:
oled_i2c_control

Overview:
- Top-level controller for an SSD1306-class OLED over a write-only I2C bus, clocked at 27 MHz.
- After reset it sends an init command sequence that turns the panel fully lit.
- Each debounced press of the active-low button toggles the display between on (0xAF) and off (0xAE); the bus can be probed with a logic analyser.

Parameters:
- CLK_DIV, 68, system clocks per SCL quarter-period (27 MHz / (4*68) ≈ 99.3 kHz SCL).
- DEBOUNCE_CYCLES, 100, consecutive stable synchronized samples needed to accept a button level.
- OLED_ADDR, 7'h3C, 7-bit I2C slave address.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  synchronous, active-high reset.
- bbutton  input  1  push button, active-low, asynchronous to clk.
- sck  output  1  I2C SCL, driven push-pull, idle high.
- sda  output  1  I2C SDA, driven push-pull, idle high.

Behaviour:
- Reset (sync, active-high): sck=1, sda=1, state=INIT_PEND, display_on=0, pending=0, debounced button=1 (released), quarter counter=0.
- Button path:
  - 2-flop synchronizer, then debounce counter; the debounced level changes only after DEBOUNCE_CYCLES equal samples.
  - A press event is a debounced 1->0 edge. Release generates nothing.
- Transaction format, one bit = 4 quarter-phases of CLK_DIV clocks each:
  - START: sda falls while sck=1, then sck low.
  - Data bits: MSB first. sda changes only while sck=0; sck high during quarters 2-3.
  - ACK slot (9th bit): sda held 1; ACK is not sampled.
  - STOP: sda 0->1 while sck=1.
  - Byte order: address byte {OLED_ADDR,1'b0}=0x78, control byte 0x00, then command bytes.
- States:
  - INIT_PEND -> INIT_TX: one clock after reset deasserts.
  - INIT_TX: one transaction with commands 0xAE, 0x8D, 0x14, 0xA5, 0xAF. At STOP completion, display_on=1 and go to IDLE.
  - IDLE: on a press or pending=1, clear pending, latch cmd = display_on ? 0xAE : 0xAF, go to CMD_TX.
  - CMD_TX: single-command transaction. At STOP completion, display_on toggles and go to IDLE.
- A press during INIT_TX or CMD_TX sets pending=1. Further presses while pending=1 are dropped (at most one queued).
- A press and transaction completion in the same cycle: pending is set; it is serviced on the next IDLE cycle.
- Gap between transactions: at least 4 quarter-periods with sck=sda=1 (bus free time).
- Reset mid-transaction: both lines go high on the next clock with no STOP generated; init restarts.
- Latency:
  - First START begins 1 clock after INIT_PEND.
  - Per byte: 9*4*CLK_DIV clocks.
  - The init transaction (7 bytes) takes about 63*4*68 ≈ 17.1k clocks plus START/STOP.

Decomposition:
- Package oled_pkg holds:
  - command constants CMD_DISPLAY_OFF=8'hAE, CMD_DISPLAY_ON=8'hAF, CMD_CHARGE_PUMP=8'h8D, CHARGE_PUMP_EN=8'h14, CMD_ENTIRE_ON=8'hA5, CTRL_CMD=8'h00;
  - the state enum;
  - the init command ROM.
- Sub-module i2c_tx_engine:
  - inputs start, byte_in, last, byte_valid; outputs byte_req, done, sck, sda;
  - owns the quarter-phase divider and bit/byte sequencing.
- The top level holds the button conditioning, state machine and command sourcing.

Test Plan:
- Reset, button idle high: first sda fall with sck=1 occurs within 2 clocks after reset release. Decoded bytes are 0x78,0x00,0xAE,0x8D,0x14,0xA5,0xAF, then STOP. display_on=1.
- Press bbutton low for 250 clocks starting at clock 1000 (during init): pending latched. After the init STOP and bus-free gap, the next transaction is 0x78,0x00,0xAE.
- Second press after idle: transaction 0x78,0x00,0xAF; display_on returns to 1.
- Glitch: bbutton low for 50 clocks (< DEBOUNCE_CYCLES) -> no transaction, sck/sda stay high.
- Three presses during a single CMD_TX -> exactly one extra transaction follows.
- Assert rst for 1 clock in the middle of byte 3 -> sck=sda=1 next clock; the full init sequence restarts. Bench checks throughout: SCL high time = 2*CLK_DIV clocks, SDA never changes while SCL is high except at START/STOP.
